// File: rtl/fifo_ram.sv
// Word storage for opaque_read_fifo: synchronous write port and an asynchronous read port.
// Contents are deliberately left unreset.
module fifo_ram #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                       clk_i,
    input  logic                       we_i,
    input  logic [$clog2(DEPTH)-1:0]   waddr_i,
    input  logic [WIDTH-1:0]           wdata_i,
    input  logic [$clog2(DEPTH)-1:0]   raddr_i,
    output logic [WIDTH-1:0]           rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/opaque_read_fifo.sv
// Receive FIFO between the UART receiver and a CPU read port: one push per Din_arrived strobe,
// one pop per ena access, with the value on io frozen for the whole access.
module opaque_read_fifo #(
    parameter int unsigned      WIDTH      = 8,
    parameter int unsigned      DEPTH      = 16,
    parameter bit               OVERWRITE  = 1'b0,
    parameter logic [WIDTH-1:0] EMPTY_CODE = '0
) (
    input  logic                     Clock,
    input  logic                     Reset,
    input  logic [WIDTH-1:0]         Din,
    input  logic                     Din_arrived,
    inout  wire  [WIDTH-1:0]         io,
    input  logic                     ena,
    input  logic                     clr_ovf,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full,
    output logic                     overflow
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [AW-1:0]    rd_ptr_q, wr_ptr_q;
    logic [CW-1:0]    count_q, count_d;
    logic             ovf_q;
    logic             ena_prev_q;
    logic             taken_q;
    logic [WIDTH-1:0] hold_q;

    logic [WIDTH-1:0] head;
    logic [WIDTH-1:0] front;
    logic             acc_start, acc_end;
    logic             pop, push_ok, blocked, overwrite;
    logic             wr_en, rd_adv;

    fifo_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk_i   (Clock),
        .we_i    (wr_en),
        .waddr_i (wr_ptr_q),
        .wdata_i (Din),
        .raddr_i (rd_ptr_q),
        .rdata_o (head)
    );

    assign empty    = (count_q == '0);
    assign full     = (count_q == CW'(DEPTH));
    assign count    = count_q;
    assign overflow = ovf_q;

    always_comb begin
        acc_start = ena & ~ena_prev_q;
        acc_end   = ~ena & ena_prev_q;
        pop       = acc_end & taken_q;
        // A pop in the same cycle frees a slot, so a full FIFO still accepts the word.
        push_ok   = Din_arrived & (~full | pop);
        blocked   = Din_arrived & full & ~pop;
        overwrite = blocked & OVERWRITE;
        wr_en     = push_ok | overwrite;
        rd_adv    = pop | overwrite;
        front     = empty ? EMPTY_CODE : head;

        count_d = count_q;
        if (push_ok && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push_ok) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
            ena_prev_q <= 1'b0;
            taken_q    <= 1'b0;
            hold_q     <= '0;
        end else begin
            ena_prev_q <= ena;
            count_q    <= count_d;
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (rd_adv) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            if (blocked) begin
                ovf_q <= 1'b1;
            end else if (clr_ovf) begin
                ovf_q <= 1'b0;
            end
            if (acc_start) begin
                hold_q <= front;
            end
            // The captured word was discarded by an overwrite, so this access must not pop.
            if (overwrite) begin
                taken_q <= 1'b0;
            end else if (acc_start) begin
                taken_q <= ~empty;
            end else if (pop) begin
                taken_q <= 1'b0;
            end
        end
    end

    assign io = (ena && !Reset) ? (ena_prev_q ? hold_q : front) : {WIDTH{1'bz}};

endmodule

// File: tb/tb_opaque_read_fifo.sv
// Directed bench for opaque_read_fifo: a default 16-deep instance plus 4-deep drop and
// overwrite instances, exercised in turn.
module tb_opaque_read_fifo;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [7:0] din     [3];
    logic       din_arr [3];
    logic       ena     [3];
    logic       clr     [3];

    wire [7:0] io_a, io_b, io_c;
    wire [4:0] cnt_a;
    wire [2:0] cnt_b, cnt_c;
    wire       em_a, em_b, em_c;
    wire       fu_a, fu_b, fu_c;
    wire       ov_a, ov_b, ov_c;

    int nvec  = 0;
    int nfail = 0;

    opaque_read_fifo #(
        .WIDTH(8), .DEPTH(16), .OVERWRITE(1'b0), .EMPTY_CODE(8'h00)
    ) u_a (
        .Clock(clk), .Reset(rst), .Din(din[0]), .Din_arrived(din_arr[0]), .io(io_a),
        .ena(ena[0]), .clr_ovf(clr[0]), .count(cnt_a), .empty(em_a), .full(fu_a),
        .overflow(ov_a)
    );

    opaque_read_fifo #(
        .WIDTH(8), .DEPTH(4), .OVERWRITE(1'b0), .EMPTY_CODE(8'h00)
    ) u_b (
        .Clock(clk), .Reset(rst), .Din(din[1]), .Din_arrived(din_arr[1]), .io(io_b),
        .ena(ena[1]), .clr_ovf(clr[1]), .count(cnt_b), .empty(em_b), .full(fu_b),
        .overflow(ov_b)
    );

    opaque_read_fifo #(
        .WIDTH(8), .DEPTH(4), .OVERWRITE(1'b1), .EMPTY_CODE(8'h00)
    ) u_c (
        .Clock(clk), .Reset(rst), .Din(din[2]), .Din_arrived(din_arr[2]), .io(io_c),
        .ena(ena[2]), .clr_ovf(clr[2]), .count(cnt_c), .empty(em_c), .full(fu_c),
        .overflow(ov_c)
    );

    function automatic logic [31:0] get_io(input int i);
        case (i)
            0:       return {24'h0, io_a};
            1:       return {24'h0, io_b};
            default: return {24'h0, io_c};
        endcase
    endfunction

    function automatic logic [31:0] get_cnt(input int i);
        case (i)
            0:       return {27'h0, cnt_a};
            1:       return {29'h0, cnt_b};
            default: return {29'h0, cnt_c};
        endcase
    endfunction

    function automatic logic [31:0] get_flags(input int i);
        // {empty, full, overflow}
        case (i)
            0:       return {29'h0, em_a, fu_a, ov_a};
            1:       return {29'h0, em_b, fu_b, ov_b};
            default: return {29'h0, em_c, fu_c, ov_c};
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp)
        else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic push(input int i, input logic [7:0] d);
        din[i]     = d;
        din_arr[i] = 1'b1;
        cyc();
        din_arr[i] = 1'b0;
    endtask

    task automatic access(input int i, input int len, input logic [7:0] exp, input int exp_cnt);
        ena[i] = 1'b1;
        #1;
        for (int k = 0; k < len; k++) begin
            chk($sformatf("io_u%0d_cyc%0d", i, k), get_io(i), {24'h0, exp});
            cyc();
        end
        ena[i] = 1'b0;
        cyc();
        chk($sformatf("count_after_read_u%0d", i), get_cnt(i), 32'(exp_cnt));
    endtask

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            din[i]     = 8'h00;
            din_arr[i] = 1'b0;
            ena[i]     = 1'b0;
            clr[i]     = 1'b0;
        end
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        cyc();

        for (int i = 0; i < 3; i++) begin
            chk($sformatf("reset_count_u%0d", i), get_cnt(i), 32'd0);
            chk($sformatf("reset_flags_u%0d", i), get_flags(i), 32'b100);
        end

        // Empty access returns EMPTY_CODE throughout and moves nothing.
        access(0, 3, 8'h00, 0);
        chk("empty_after_empty_read", get_flags(0), 32'b100);

        // Two words, two accesses separated by a low cycle.
        push(0, 8'h41);
        push(0, 8'h42);
        chk("count_two_pushed", get_cnt(0), 32'd2);
        chk("flags_two_pushed", get_flags(0), 32'b000);
        access(0, 1, 8'h41, 1);
        access(0, 1, 8'h42, 0);
        chk("flags_drained", get_flags(0), 32'b100);

        // Push lands mid-access that started empty: io stays EMPTY_CODE, no pop.
        ena[0] = 1'b1;
        #1;
        chk("mid_push_io0", get_io(0), 32'h00);
        cyc();
        chk("mid_push_io1", get_io(0), 32'h00);
        din[0]     = 8'h55;
        din_arr[0] = 1'b1;
        cyc();
        din_arr[0] = 1'b0;
        chk("mid_push_io2", get_io(0), 32'h00);
        chk("mid_push_count", get_cnt(0), 32'd1);
        cyc();
        chk("mid_push_io3", get_io(0), 32'h00);
        ena[0] = 1'b0;
        cyc();
        chk("mid_push_no_pop", get_cnt(0), 32'd1);
        access(0, 2, 8'h55, 0);

        // Drop policy: fifth word is lost.
        for (int k = 1; k <= 5; k++) push(1, 8'(k));
        chk("drop_count", get_cnt(1), 32'd4);
        chk("drop_flags", get_flags(1), 32'b011);
        for (int k = 1; k <= 4; k++) access(1, 1, 8'(k), 4 - k);
        chk("drop_drained_flags", get_flags(1), 32'b101);
        clr[1] = 1'b1;
        cyc();
        clr[1] = 1'b0;
        chk("drop_clr_ovf", get_flags(1), 32'b100);

        // Full FIFO, push on the edge where the access ends: no overflow.
        push(1, 8'h11);
        push(1, 8'h22);
        push(1, 8'h33);
        push(1, 8'h44);
        chk("full_before_swap", get_flags(1), 32'b010);
        ena[1] = 1'b1;
        #1;
        chk("swap_io", get_io(1), 32'h11);
        cyc();
        ena[1]     = 1'b0;
        din[1]     = 8'h55;
        din_arr[1] = 1'b1;
        cyc();
        din_arr[1] = 1'b0;
        chk("swap_count", get_cnt(1), 32'd4);
        chk("swap_flags", get_flags(1), 32'b010);
        access(1, 1, 8'h22, 3);
        access(1, 1, 8'h33, 2);
        access(1, 1, 8'h44, 1);
        access(1, 1, 8'h55, 0);

        // Overwrite policy: oldest two words are replaced.
        for (int k = 1; k <= 6; k++) push(2, 8'(k));
        chk("ovw_count", get_cnt(2), 32'd4);
        chk("ovw_flags", get_flags(2), 32'b011);
        for (int k = 3; k <= 6; k++) access(2, 1, 8'(k), 6 - k);
        clr[2] = 1'b1;
        cyc();
        clr[2] = 1'b0;
        chk("ovw_clr_ovf", get_flags(2), 32'b100);

        // Overwrite of the word held by an in-progress access: no later pop.
        push(2, 8'hA0);
        push(2, 8'hB0);
        push(2, 8'hC0);
        push(2, 8'hD0);
        ena[2] = 1'b1;
        #1;
        chk("hold_ovw_io0", get_io(2), 32'hA0);
        cyc();
        din[2]     = 8'hE0;
        din_arr[2] = 1'b1;
        cyc();
        din_arr[2] = 1'b0;
        chk("hold_ovw_io1", get_io(2), 32'hA0);
        chk("hold_ovw_flags", get_flags(2), 32'b011);
        ena[2] = 1'b0;
        cyc();
        chk("hold_ovw_no_pop", get_cnt(2), 32'd4);
        access(2, 1, 8'hB0, 3);
        access(2, 1, 8'hC0, 2);
        access(2, 1, 8'hD0, 1);
        access(2, 1, 8'hE0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule

// File: doc/opaque_read_fifo.md
# opaque_read_fifo

Parametrised successor to the single-byte opaque read buffer between the UART receiver and a CPU I/O port. Incoming words are pushed into a DEPTH-entry ring buffer on each arrival strobe. The CPU pops one word per `ena` access over the tri-state `io` bus. Status outputs are provided, and overflow is handled in a selectable mode, so bursts on RX are not lost while the CPU is busy.

## Interface
- WIDTH, 8, data word width (io and Din)
- DEPTH, 16, FIFO entries; power of two, ≥2
- OVERWRITE, 0, full-policy: 0 = drop incoming word, 1 = discard oldest and accept incoming
- EMPTY_CODE, 8'h00, value driven on io when an access finds the FIFO empty (WIDTH bits)
- Clock  input  1  single clock; all state on rising edge
- Reset  input  1  asynchronous, active-high
- Din  input  WIDTH  received word
- Din_arrived  input  1  one-cycle push strobe; Din valid same cycle
- io  inout  WIDTH  CPU data bus; driven only while ena=1, else high-Z
- ena  input  1  CPU access select for this port; one high interval = one read access
- clr_ovf  input  1  synchronous clear of overflow flag
- count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
- empty  output  1  count==0
- full  output  1  count==DEPTH
- overflow  output  1  sticky: set when a word was dropped or overwritten

## Operation
- Access detection: register ena_d <= ena.
  - Access start = ena & ~ena_d.
  - Access end = ~ena & ena_d.
- At access start, capture:
  - hold <= empty ? EMPTY_CODE : head
  - taken <= ~empty
- io drive while ena=1:
  - first cycle (ena_d=0): combinational (empty ? EMPTY_CODE : head)
  - later cycles: hold
  - value is therefore stable for the whole access even if a push lands mid-access
- Pop: at access end, if taken; rd_ptr++, taken cleared. Exactly one pop per access, however long ena stays high.
- Push: on Din_arrived.
  - Not full: write Din at wr_ptr, wr_ptr++.
  - Full, OVERWRITE=0: word dropped, overflow set, pointers unchanged.
  - Full, OVERWRITE=1: write at wr_ptr, wr_ptr++, rd_ptr++ (count stays DEPTH), overflow set.
- Simultaneous push and pop in one cycle:
  - Both occur; count unchanged.
  - When full, the pop frees a slot, so there is no overflow and no overwrite.
- OVERWRITE=1 with an access in progress: if the oldest word (the one captured in hold) is overwritten, taken is cleared so the later pop does not skip a second word. The CPU still receives the old hold value.
- Pointers are AW=$clog2(DEPTH) bits wide and wrap modulo DEPTH. count is tracked separately and is never derived from pointer difference alone.
- overflow: set has priority over clr_ovf in the same cycle.

## Timing
- Reset (asynchronous) values:
  - rd_ptr = wr_ptr = 0, count = 0, empty = 1, full = 0, overflow = 0
  - hold = 0, taken = 0, ena_d = 0
  - io = high-Z
  - memory contents not reset
- Push latency: Din_arrived at cycle n → count/empty/full updated at n+1; the word is visible on io for an access starting at n+1 or later.
- Pop latency: ena falls at cycle n → count updates at n+1.
- Minimum access length is 1 cycle. A 1-cycle ena gives start and end on consecutive edges, which is legal.
- Back-to-back accesses need ena low for ≥1 cycle; the next access then sees the advanced head.
- Reset during an access: io goes high-Z when ena drops or immediately if Reset; state returns to the reset values; no pop.
- Status outputs are registered (count) or derived from count. No combinational path from Din_arrived to the status outputs.

## Structure
- No shared package: all constants are module parameters.
- One sub-module, fifo_ram:
  - WIDTH×DEPTH storage
  - synchronous write
  - asynchronous read at rd_ptr
- The top level holds pointers, count, access FSM (ena_d/taken/hold), overflow and tri-state drive.

## Test plan
- Reset, then 3-cycle ena access with no pushes → io=8'h00 (EMPTY_CODE) throughout; count stays 0; no pointer movement.
- Push 8'h41, 8'h42; two accesses separated by a low cycle → reads 8'h41 then 8'h42; count 2→1→0; empty=1 at end.
- OVERWRITE=0, DEPTH=4: push 1,2,3,4,5 → full=1, overflow=1, reads 1,2,3,4; clr_ovf → overflow=0.
- OVERWRITE=1, DEPTH=4: push 1..6 → count=4, overflow=1, reads 3,4,5,6.
- Full FIFO, push on the same cycle ena falls → count stays DEPTH, no overflow, new word read last.
- Push 8'h55 on the second cycle of an access that started empty → io holds 8'h00 for the access, no pop; next access reads 8'h55.
